psram_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate read cache between the bus PSRAM port and the PSRAM controller (psram_top). It serves repeated core reads of PSRAM-resident code and data from on-chip flops, refills 4-word lines on a miss, and forwards every write downstream. Both sides use the native valid/ready memory handshake of the core bus.

---
 rtl/psram_cache_pkg.sv | 15 +
 rtl/psram_cache_array.sv | 60 ++++++
 rtl/psram_cache.sv | 253 +++++++++++++++++++++++++
 tb/tb_psram_cache.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_cache_pkg.sv
// Shared types and constants for the PSRAM read cache.
package psram_cache_pkg;

    localparam int LINE_WORDS = 4;
    localparam int OFF_W      = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_REFILL = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/psram_cache_array.sv
// Flop-based tag/valid/data storage for the PSRAM cache: one read port,
// a refill word-write port, a byte-merge write port and a clear-all port.
module psram_cache_array
    import psram_cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int TAG_W = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_clr,
    input  logic [$clog2(LINES)-1:0]  i_idx,
    input  logic [OFF_W-1:0]          i_off,
    input  logic [TAG_W-1:0]          i_tag,
    output logic                      o_rd_valid,
    output logic [TAG_W-1:0]          o_rd_tag,
    output logic [31:0]               o_rd_word,
    input  logic                      i_ref_we,
    input  logic [OFF_W-1:0]          i_ref_off,
    input  logic [31:0]               i_ref_data,
    input  logic                      i_ref_done,
    input  logic                      i_mrg_we,
    input  logic [31:0]               i_mrg_data,
    input  logic [3:0]                i_mrg_strb
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES][LINE_WORDS];

    assign o_rd_valid = r_valid[i_idx];
    assign o_rd_tag   = r_tag[i_idx];
    assign o_rd_word  = r_data[i_idx][i_off];

    // Only the valid bits need a reset; tag and data are qualified by them.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_valid <= '0;
        end else if (i_ref_done) begin
            r_valid[i_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_ref_we) begin
            r_data[i_idx][i_ref_off] <= i_ref_data;
        end
        if (i_ref_done) begin
            r_tag[i_idx] <= i_tag;
        end
        if (i_mrg_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_mrg_strb[b]) begin
                    r_data[i_idx][i_off][b*8 +: 8] <= i_mrg_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/psram_cache.sv
// Direct-mapped, write-through, no-write-allocate read cache in front of the
// PSRAM controller. Define PSRAM_CACHE_STAT_EN to add read hit/miss counters.
module psram_cache
    import psram_cache_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int LINES  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inv_i,
    input  logic              up_valid_i,
    input  logic [ADDR_W-1:0] up_addr_i,
    input  logic [31:0]       up_wdata_i,
    input  logic [3:0]        up_wstrb_i,
    output logic [31:0]       up_rdata_o,
    output logic              up_ready_o,
    output logic              dn_valid_o,
    output logic [ADDR_W-1:0] dn_addr_o,
    output logic [31:0]       dn_wdata_o,
    output logic [3:0]        dn_wstrb_o,
    input  logic [31:0]       dn_rdata_i,
    input  logic              dn_ready_i
`ifdef PSRAM_CACHE_STAT_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

    // Handshake: a request is taken when up_valid_i is seen in IDLE and must stay
    // high until the one-cycle up_ready_o pulse; each dn_valid_o is held until
    // the one-cycle dn_ready_i pulse and drops in the following cycle.
    state_t r_state, w_state_nxt;

    logic [ADDR_W-1:2] r_addr,       w_addr_nxt;
    logic [31:0]       r_wdata,      w_wdata_nxt;
    logic [3:0]        r_wstrb,      w_wstrb_nxt;
    logic [OFF_W-1:0]  r_cnt,        w_cnt_nxt;
    logic              r_inv_pend,   w_inv_pend_nxt;
    logic              r_up_ready,   w_up_ready_nxt;
    logic [31:0]       r_up_rdata,   w_up_rdata_nxt;
    logic              r_dn_valid,   w_dn_valid_nxt;
    logic [ADDR_W-1:0] r_dn_addr,    w_dn_addr_nxt;
    logic [31:0]       r_dn_wdata,   w_dn_wdata_nxt;
    logic [3:0]        r_dn_wstrb,   w_dn_wstrb_nxt;
`ifdef PSRAM_CACHE_STAT_EN
    logic [31:0]       r_hit_cnt,    w_hit_cnt_nxt;
    logic [31:0]       r_miss_cnt,   w_miss_cnt_nxt;
`endif

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [OFF_W-1:0]  w_off;
    logic              w_rd_valid;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [31:0]       w_rd_word;
    logic              w_hit;
    logic              w_is_write;
    logic              w_inv;
    logic              w_dn_done;
    logic              w_clr, w_ref_we, w_ref_done, w_mrg_we;
    logic              w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^up_addr_i[1:0];

    assign w_idx      = r_addr[4 +: IDX_W];
    assign w_tag      = r_addr[ADDR_W-1 -: TAG_W];
    assign w_off      = r_addr[3:2];
    assign w_hit      = w_rd_valid && (w_rd_tag == w_tag);
    assign w_is_write = (r_wstrb != 4'b0000);
    assign w_inv      = r_inv_pend || inv_i;
    assign w_dn_done  = r_dn_valid && dn_ready_i;

    psram_cache_array #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_array (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_clr      (w_clr),
        .i_idx      (w_idx),
        .i_off      (w_off),
        .i_tag      (w_tag),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_word  (w_rd_word),
        .i_ref_we   (w_ref_we),
        .i_ref_off  (r_cnt),
        .i_ref_data (dn_rdata_i),
        .i_ref_done (w_ref_done),
        .i_mrg_we   (w_mrg_we),
        .i_mrg_data (r_wdata),
        .i_mrg_strb (r_wstrb)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pending invalidate wins over accepting a request in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (!w_inv && up_valid_i) w_state_nxt = ST_LOOKUP;
            ST_LOOKUP: begin
                if (w_is_write)  w_state_nxt = ST_WRITE;
                else if (w_hit)  w_state_nxt = ST_RESP;
                else             w_state_nxt = ST_REFILL;
            end
            ST_REFILL: if (w_dn_done && r_cnt == OFF_W'(LINE_WORDS - 1)) w_state_nxt = ST_RESP;
            ST_WRITE:  if (w_dn_done) w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_wstrb_nxt    = r_wstrb;
        w_cnt_nxt      = r_cnt;
        w_inv_pend_nxt = r_inv_pend || inv_i;
        w_up_ready_nxt = 1'b0;
        w_up_rdata_nxt = r_up_rdata;
        w_dn_valid_nxt = r_dn_valid;
        w_dn_addr_nxt  = r_dn_addr;
        w_dn_wdata_nxt = r_dn_wdata;
        w_dn_wstrb_nxt = r_dn_wstrb;
`ifdef PSRAM_CACHE_STAT_EN
        w_hit_cnt_nxt  = r_hit_cnt;
        w_miss_cnt_nxt = r_miss_cnt;
`endif
        w_clr          = 1'b0;
        w_ref_we       = 1'b0;
        w_ref_done     = 1'b0;
        w_mrg_we       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_inv) begin
                    w_clr          = 1'b1;
                    w_inv_pend_nxt = 1'b0;
                end else if (up_valid_i) begin
                    w_addr_nxt  = up_addr_i[ADDR_W-1:2];
                    w_wdata_nxt = up_wdata_i;
                    w_wstrb_nxt = up_wstrb_i;
                end
            end
            ST_LOOKUP: begin
                if (w_is_write) begin
                    w_dn_valid_nxt = 1'b1;
                    w_dn_addr_nxt  = {r_addr, 2'b00};
                    w_dn_wdata_nxt = r_wdata;
                    w_dn_wstrb_nxt = r_wstrb;
                end else if (w_hit) begin
                    w_up_ready_nxt = 1'b1;
                    w_up_rdata_nxt = w_rd_word;
`ifdef PSRAM_CACHE_STAT_EN
                    w_hit_cnt_nxt  = r_hit_cnt + 32'd1;
`endif
                end else begin
                    w_cnt_nxt      = '0;
                    w_dn_valid_nxt = 1'b1;
                    w_dn_addr_nxt  = {r_addr[ADDR_W-1:4], {OFF_W{1'b0}}, 2'b00};
                    w_dn_wstrb_nxt = 4'b0000;
`ifdef PSRAM_CACHE_STAT_EN
                    w_miss_cnt_nxt = r_miss_cnt + 32'd1;
`endif
                end
            end
            ST_REFILL: begin
                if (w_dn_done) begin
                    w_ref_we       = 1'b1;
                    w_dn_valid_nxt = 1'b0;
                    if (r_cnt == OFF_W'(LINE_WORDS - 1)) begin
                        // Last word is still on dn_rdata_i, not yet in the array.
                        w_ref_done     = 1'b1;
                        w_up_ready_nxt = 1'b1;
                        w_up_rdata_nxt = (w_off == r_cnt) ? dn_rdata_i : w_rd_word;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else if (!r_dn_valid) begin
                    w_dn_valid_nxt = 1'b1;
                    w_dn_addr_nxt  = {r_addr[ADDR_W-1:4], r_cnt, 2'b00};
                end
            end
            ST_WRITE: begin
                if (w_dn_done) begin
                    w_dn_valid_nxt = 1'b0;
                    w_mrg_we       = w_hit;
                    w_up_ready_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_cnt      <= '0;
            r_inv_pend <= 1'b0;
            r_up_ready <= 1'b0;
            r_up_rdata <= '0;
            r_dn_valid <= 1'b0;
            r_dn_addr  <= '0;
            r_dn_wdata <= '0;
            r_dn_wstrb <= '0;
`ifdef PSRAM_CACHE_STAT_EN
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
`endif
        end else begin
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_wstrb    <= w_wstrb_nxt;
            r_cnt      <= w_cnt_nxt;
            r_inv_pend <= w_inv_pend_nxt;
            r_up_ready <= w_up_ready_nxt;
            r_up_rdata <= w_up_rdata_nxt;
            r_dn_valid <= w_dn_valid_nxt;
            r_dn_addr  <= w_dn_addr_nxt;
            r_dn_wdata <= w_dn_wdata_nxt;
            r_dn_wstrb <= w_dn_wstrb_nxt;
`ifdef PSRAM_CACHE_STAT_EN
            r_hit_cnt  <= w_hit_cnt_nxt;
            r_miss_cnt <= w_miss_cnt_nxt;
`endif
        end
    end

    assign up_ready_o = r_up_ready;
    assign up_rdata_o = r_up_rdata;
    assign dn_valid_o = r_dn_valid;
    assign dn_addr_o  = r_dn_addr;
    assign dn_wdata_o = r_dn_wdata;
    assign dn_wstrb_o = r_dn_wstrb;
`ifdef PSRAM_CACHE_STAT_EN
    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_psram_cache.sv
// Directed bench for psram_cache: downstream PSRAM responder with a word
// memory, upstream request driver, and a queue of expected downstream beats.
module tb_psram_cache;

    logic        clk = 1'b0;
    logic        rst_i, inv_i;
    logic        up_valid_i;
    logic [23:0] up_addr_i;
    logic [31:0] up_wdata_i;
    logic [3:0]  up_wstrb_i;
    logic [31:0] up_rdata_o;
    logic        up_ready_o;
    logic        dn_valid_o;
    logic [23:0] dn_addr_o;
    logic [31:0] dn_wdata_o;
    logic [3:0]  dn_wstrb_o;
    logic [31:0] dn_rdata_i;
    logic        dn_ready_i;
`ifdef PSRAM_CACHE_STAT_EN
    logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 1;
    int wait_cnt = 0;

    // Downstream beat record: {wstrb, wdata (0 for reads), addr}.
    logic [59:0] exp_q[$];
    logic [59:0] obs_q[$];
    logic [31:0] mem [logic [23:0]];

    psram_cache u_dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .inv_i      (inv_i),
        .up_valid_i (up_valid_i),
        .up_addr_i  (up_addr_i),
        .up_wdata_i (up_wdata_i),
        .up_wstrb_i (up_wstrb_i),
        .up_rdata_o (up_rdata_o),
        .up_ready_o (up_ready_o),
        .dn_valid_o (dn_valid_o),
        .dn_addr_o  (dn_addr_o),
        .dn_wdata_o (dn_wdata_o),
        .dn_wstrb_o (dn_wstrb_o),
        .dn_rdata_i (dn_rdata_i),
        .dn_ready_i (dn_ready_i)
`ifdef PSRAM_CACHE_STAT_EN
        ,
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [23:0] a);
        return mem.exists(a) ? mem[a] : {8'hC0, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // PSRAM responder: ready pulse after lat cycles of valid, one beat per pulse.
    initial begin
        dn_ready_i = 1'b0;
        dn_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (dn_ready_i) begin
                dn_ready_i = 1'b0;
            end else if (dn_valid_o && !rst_i) begin
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    logic [31:0] w;
                    wait_cnt   = 0;
                    dn_ready_i = 1'b1;
                    if (dn_wstrb_o == 4'b0000) begin
                        dn_rdata_i = mem_rd(dn_addr_o);
                        obs_q.push_back({4'h0, 32'h0, dn_addr_o});
                    end else begin
                        w = mem_rd(dn_addr_o);
                        for (int b = 0; b < 4; b++)
                            if (dn_wstrb_o[b]) w[b*8 +: 8] = dn_wdata_o[b*8 +: 8];
                        mem[dn_addr_o] = w;
                        obs_q.push_back({dn_wstrb_o, dn_wdata_o, dn_addr_o});
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_req(input logic [23:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input int inv_at, output logic [31:0] rd, output int cyc);
        @(negedge clk);
        up_valid_i = 1'b1;
        up_addr_i  = a;
        up_wdata_i = wd;
        up_wstrb_i = ws;
        inv_i      = (inv_at == 0);
        cyc = 0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            inv_i = (cyc == inv_at);
            if (up_ready_o) break;
        end
        check("req_done", up_ready_o, 1'b1);
        rd         = up_rdata_o;
        up_valid_i = 1'b0;
        inv_i      = 1'b0;
    endtask

    task automatic exp_line(input logic [23:0] base);
        for (int i = 0; i < 4; i++) exp_q.push_back({4'h0, 32'h0, base + 24'(4*i)});
    endtask

    task automatic check_dn(input string tag);
        check({tag, "_ntx"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_tx"}, obs_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic rd_chk(input string tag, input logic [23:0] a, input logic [31:0] exp_d,
                          input int exp_cyc, input int inv_at);
        logic [31:0] rd;
        int cyc;
        do_req(a, 32'h0, 4'h0, inv_at, rd, cyc);
        check({tag, "_data"}, rd, exp_d);
        check({tag, "_lat"}, cyc, exp_cyc);
        check_dn(tag);
    endtask

    task automatic wr_chk(input string tag, input logic [23:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        logic [31:0] rd;
        int cyc;
        exp_q.push_back({s, d, a[23:2], 2'b00});
        do_req(a, d, s, -1, rd, cyc);
        check({tag, "_lat"}, cyc, 3);
        check_dn(tag);
    endtask

    task automatic reset_outputs_chk(input string tag);
        check({tag, "_up_ready"}, up_ready_o, 1'b0);
        check({tag, "_up_rdata"}, up_rdata_o, 32'h0);
        check({tag, "_dn_valid"}, dn_valid_o, 1'b0);
        check({tag, "_dn_addr"},  dn_addr_o,  24'h0);
        check({tag, "_dn_wdata"}, dn_wdata_o, 32'h0);
        check({tag, "_dn_wstrb"}, dn_wstrb_o, 4'h0);
`ifdef PSRAM_CACHE_STAT_EN
        check({tag, "_hit_cnt"},  hit_cnt_o,  32'h0);
        check({tag, "_miss_cnt"}, miss_cnt_o, 32'h0);
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_i = 1'b1; inv_i = 1'b0; up_valid_i = 1'b0;
        up_addr_i = '0; up_wdata_i = '0; up_wstrb_i = '0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        reset_outputs_chk("rst");

        // Cold miss, then hits on the refilled line.
        exp_line(24'h000100);
        rd_chk("cold_100", 24'h000100, 32'hC000_0100, 9, -1);
        rd_chk("hit_104", 24'h000104, 32'hC000_0104, 2, -1);

        // Write-through with byte merge into a cached line.
        wr_chk("wr_104", 24'h000104, 32'hDEAD_BEEF, 4'b0011);
        rd_chk("hit_104m", 24'h000104, 32'hC000_BEEF, 2, -1);
        wr_chk("wr_10a", 24'h00010A, 32'h00AB_0000, 4'b0100);
        rd_chk("hit_108m", 24'h000108, 32'hC0AB_0108, 2, -1);

        // No-write-allocate: write to an uncached line, then read misses.
        wr_chk("wr_300", 24'h000300, 32'h1234_5678, 4'b1111);
        exp_line(24'h000300);
        rd_chk("miss_300", 24'h000300, 32'h1234_5678, 9, -1);

        // Same index, slow downstream: 0x200 evicts, then 0x100 misses again.
        lat = 3;
        exp_line(24'h000200);
        rd_chk("evict_200", 24'h000200, 32'hC000_0200, 17, -1);
        lat = 1;
        exp_line(24'h000100);
        rd_chk("remiss_100", 24'h000100, 32'hC000_0100, 9, -1);

        // inv_i during refill: read completes, next read misses one cycle late.
        exp_line(24'h000400);
        rd_chk("inv_refill", 24'h000400, 32'hC000_0400, 9, 4);
        exp_line(24'h000400);
        rd_chk("inv_after", 24'h000400, 32'hC000_0400, 10, -1);
        // inv_i coincident with acceptance.
        exp_line(24'h000400);
        rd_chk("inv_accept", 24'h000404, 32'hC000_0404, 10, 0);

        // Reset in the middle of a refill.
        @(negedge clk);
        up_valid_i = 1'b1; up_addr_i = 24'h000500; up_wstrb_i = 4'h0;
        k = 0;
        while (!dn_valid_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("mid_dn_valid_seen", dn_valid_o, 1'b1);
        rst_i = 1'b1;
        up_valid_i = 1'b0;
        @(negedge clk);
        check("mid_rst_dn_valid", dn_valid_o, 1'b0);
        check("mid_rst_up_ready", up_ready_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        reset_outputs_chk("mid_rst");
        obs_q.delete();
        exp_q.delete();

        // After reset every line is invalid; then 3 hits and 2 misses.
        exp_line(24'h000400);
        rd_chk("post_rst_400", 24'h000400, 32'hC000_0400, 9, -1);
        rd_chk("post_hit_404", 24'h000404, 32'hC000_0404, 2, -1);
        rd_chk("post_hit_40c", 24'h00040C, 32'hC000_040C, 2, -1);
        exp_line(24'h000100);
        rd_chk("post_miss_100", 24'h000100, 32'hC000_0100, 9, -1);
        rd_chk("post_hit_104", 24'h000104, 32'hC000_BEEF, 2, -1);
`ifdef PSRAM_CACHE_STAT_EN
        check("stat_hits", hit_cnt_o, 32'd3);
        check("stat_misses", miss_cnt_o, 32'd2);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
